// File: rtl/fifo_access_ctrl.sv
// Round-robin push arbiter and burst-read sequencer in front of a shared synchronous FIFO.
// push/gnt/pop are combinational; ful stalls pushes, ept stalls pops; first rd_valid 3 cycles after rd_start.
module fifo_access_ctrl #(
  parameter int WIDTH  = 8,
  parameter int NREQ   = 4,
  parameter int SIZE_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_push,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_gnt,
  output logic                    push,
  output logic [WIDTH-1:0]        w_data,
  input  logic                    ful,
  output logic                    pop,
  input  logic [WIDTH-1:0]        r_data,
  input  logic                    ept,
  input  logic                    valid,
  input  logic                    rd_start,
  input  logic [SIZE_W-1:0]       rd_size,
  output logic                    rd_busy,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_valid,
  output logic                    rd_done
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  winner, idx;
  logic              found, grant;

  state_t            state_q, state_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] issued_q, issued_d;
  logic [SIZE_W-1:0] received_q, received_d;
  logic              rd_busy_q, rd_busy_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_done_q, rd_done_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              pop_int;

  // Scan requesters starting at the pointer so the last winner drops to lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!found && req_push[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end

    grant   = found && !ful && reset;
    push    = grant;
    req_gnt = '0;
    w_data  = '0;
    ptr_d   = ptr_q;
    if (grant) begin
      req_gnt[winner] = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (int'(winner) == i) begin
          w_data = req_data[i*WIDTH +: WIDTH];
        end
      end
      ptr_d = (int'(winner) == NREQ - 1) ? '0 : winner + PTR_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    issued_d   = issued_q;
    received_d = received_q;
    rd_busy_d  = rd_busy_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    pop_int    = 1'b0;

    if ((state_q == BURST || state_q == DRAIN) && valid) begin
      rd_data_d  = r_data;
      rd_valid_d = 1'b1;
      received_d = received_q + SIZE_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (rd_size != '0) begin
            size_d     = rd_size;
            issued_d   = '0;
            received_d = '0;
            rd_busy_d  = 1'b1;
            state_d    = BURST;
          end else begin
            rd_done_d = 1'b1;
          end
        end
      end
      BURST: begin
        if ((issued_q < size_q) && !ept) begin
          pop_int  = 1'b1;
          issued_d = issued_q + SIZE_W'(1);
        end
        if (issued_d == size_q) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Done coincides with the registered last word.
        if (valid && (received_q + SIZE_W'(1) == size_q)) begin
          state_d   = IDLE;
          rd_busy_d = 1'b0;
          rd_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pop = pop_int && reset;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q      <= '0;
      state_q    <= IDLE;
      size_q     <= '0;
      issued_q   <= '0;
      received_q <= '0;
      rd_busy_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      state_q    <= state_d;
      size_q     <= size_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      rd_busy_q  <= rd_busy_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_busy  = rd_busy_q;
  assign rd_valid = rd_valid_q;
  assign rd_done  = rd_done_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: the bench plays requesters and the FIFO, and checks every cycle against a reference model.
module tb_fifo_access_ctrl;
  localparam int WIDTH  = 8;
  localparam int NREQ   = 4;
  localparam int SIZE_W = 32;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_push;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_gnt;
  logic                  push;
  logic [WIDTH-1:0]      w_data;
  logic                  ful;
  logic                  pop;
  logic [WIDTH-1:0]      r_data;
  logic                  ept;
  logic                  valid;
  logic                  rd_start;
  logic [SIZE_W-1:0]     rd_size;
  logic                  rd_busy;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_valid;
  logic                  rd_done;

  fifo_access_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .SIZE_W(SIZE_W)) dut (
    .clock(clock), .reset(reset),
    .req_push(req_push), .req_data(req_data), .req_gnt(req_gnt),
    .push(push), .w_data(w_data), .ful(ful),
    .pop(pop), .r_data(r_data), .ept(ept), .valid(valid),
    .rd_start(rd_start), .rd_size(rd_size),
    .rd_busy(rd_busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done)
  );

  always #5 clock = ~clock;

  // Requester word queues (circular, 8-bit indices) and the FIFO contents.
  logic [7:0] rmem [NREQ][256];
  logic [7:0] rhead [NREQ];
  logic [7:0] rtail [NREQ];
  logic [7:0] fq [$];
  logic [7:0] rlog [$];
  int         depth;
  bit         force_ful;

  // Reference model: pointer, burst progress counts, and predicted registered outputs.
  int         m_ptr, m_size, m_popped, m_recv;
  bit         m_phase;
  bit         e_valid, e_done, e_busy;
  logic [7:0] e_data;

  // Values sampled mid-cycle.
  logic       s_push, s_pop, s_rd_valid, s_rd_done, s_rd_busy;
  logic [3:0] s_gnt;
  logic [7:0] s_wdata, s_rd_data;

  int n_pass, n_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [7:0] w);
    rmem[i][rtail[i]] = w;
    rtail[i] = rtail[i] + 8'd1;
  endtask

  task automatic drive_env();
    for (int i = 0; i < NREQ; i++) begin
      req_push[i] = (rhead[i] != rtail[i]);
      req_data[i*WIDTH +: WIDTH] = req_push[i] ? rmem[i][rhead[i]] : 8'h00;
    end
    ful = force_ful || (fq.size() >= depth);
    ept = (fq.size() == 0);
  endtask

  task automatic cycle();
    int win;
    bit e_pop, nv, nd;
    drive_env();
    @(negedge clock);
    win = -1;
    if (reset && !ful && req_push != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        if (win < 0 && req_push[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      end
    end
    e_pop = reset && m_phase && (m_popped < m_size) && !ept;
    s_push = push; s_gnt = req_gnt; s_wdata = w_data; s_pop = pop;
    s_rd_valid = rd_valid; s_rd_done = rd_done; s_rd_busy = rd_busy; s_rd_data = rd_data;
    chk("push", 32'(push), 32'(win >= 0));
    chk("req_gnt", 32'(req_gnt), (win >= 0) ? 32'(1 << win) : 32'd0);
    if (win >= 0) chk("w_data", 32'(w_data), 32'(rmem[win][rhead[win]]));
    chk("pop", 32'(pop), 32'(e_pop));
    chk("rd_valid", 32'(rd_valid), 32'(e_valid));
    chk("rd_done", 32'(rd_done), 32'(e_done));
    chk("rd_busy", 32'(rd_busy), 32'(e_busy));
    if (e_valid) chk("rd_data", 32'(rd_data), 32'(e_data));
    if (s_rd_valid) rlog.push_back(s_rd_data);
    @(posedge clock);
    #1;
    if (!reset) begin
      m_ptr = 0; m_phase = 0; e_valid = 0; e_done = 0; e_busy = 0; e_data = 8'h00;
    end else begin
      nv = 0; nd = 0;
      if (win >= 0) m_ptr = (win + 1) % NREQ;
      if (m_phase) begin
        if (valid) begin e_data = r_data; nv = 1; m_recv++; end
        if (e_pop) m_popped++;
        if (m_recv == m_size) begin m_phase = 0; nd = 1; end
      end else if (rd_start) begin
        if (rd_size != 0) begin
          m_phase = 1; m_size = int'(rd_size); m_popped = 0; m_recv = 0;
        end else begin
          nd = 1;
        end
      end
      e_valid = nv; e_done = nd; e_busy = m_phase;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (s_gnt[i] && rhead[i] != rtail[i]) rhead[i] = rhead[i] + 8'd1;
    end
    valid = 1'b0;
    if (!reset) begin
      fq.delete();
    end else begin
      if (s_pop && fq.size() > 0) begin r_data = fq.pop_front(); valid = 1'b1; end
      if (s_push) fq.push_back(s_wdata);
    end
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (s_rd_done) break;
    end
    chk("done_seen", 32'(s_rd_done), 32'd1);
  endtask

  initial begin
    int np, nd;
    n_pass = 0; n_total = 0;
    reset = 1'b0; valid = 1'b0; r_data = '0; rd_start = 1'b0; rd_size = '0;
    req_push = '0; req_data = '0; ful = 1'b0; ept = 1'b1;
    force_ful = 1'b0; depth = 16;
    m_ptr = 0; m_size = 0; m_popped = 0; m_recv = 0; m_phase = 0;
    e_valid = 0; e_done = 0; e_busy = 0; e_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin rhead[i] = 8'd0; rtail[i] = 8'd0; end

    // Reset, then idle.
    repeat (3) cycle();
    chk("rst_rd_data", 32'(s_rd_data), 32'd0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("idle_gnt", 32'(s_gnt), 32'd0);
      chk("idle_pop", 32'(s_pop), 32'd0);
    end

    // Round-robin with every requester active.
    for (int i = 0; i < NREQ; i++) begin load(i, 8'(8'h10 * i)); load(i, 8'(8'h10 * i + 1)); end
    for (int c = 0; c < 8; c++) begin
      cycle();
      chk("rr_order", 32'(s_gnt), 32'(1 << (c % 4)));
    end
    rd_start = 1'b1; rd_size = 8;
    rlog.delete();
    wait_done(40);
    chk("drain8_cnt", 32'(rlog.size()), 32'd8);

    // Full back-pressure holds the pointer.
    load(0, 8'h55); load(2, 8'h77);
    force_ful = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("ful_gnt", 32'(s_gnt), 32'd0);
      chk("ful_push", 32'(s_push), 32'd0);
    end
    force_ful = 1'b0;
    cycle(); chk("ful_rel0", 32'(s_gnt), 32'b0001);
    cycle(); chk("ful_rel2", 32'(s_gnt), 32'b0100);
    rd_start = 1'b1; rd_size = 2;
    wait_done(20);

    // Four-word burst.
    for (int j = 0; j < 4; j++) load(1, 8'(8'hA1 + j));
    repeat (4) cycle();
    rlog.delete();
    rd_start = 1'b1; rd_size = 4;
    cycle();
    chk("start_no_pop", 32'(s_pop), 32'd0);
    for (int j = 0; j < 4; j++) begin cycle(); chk("burst_pop", 32'(s_pop), 32'd1); end
    wait_done(10);
    chk("done_with_A4", 32'(s_rd_data), 32'hA4);
    chk("done_valid", 32'(s_rd_valid), 32'd1);
    chk("burst_n", 32'(rlog.size()), 32'd4);
    for (int j = 0; j < rlog.size(); j++) chk("burst_data", 32'(rlog[j]), 32'(8'hA1 + j));
    cycle();
    chk("busy_after", 32'(s_rd_busy), 32'd0);

    // Empty stall mid-burst.
    load(3, 8'hB1);
    cycle();
    rlog.delete();
    rd_start = 1'b1; rd_size = 3;
    cycle();
    np = 0;
    for (int j = 0; j < 6; j++) begin cycle(); np += int'(s_pop); end
    chk("stall_pops", 32'(np), 32'd1);
    chk("stall_busy", 32'(s_rd_busy), 32'd1);
    load(3, 8'hB2); load(3, 8'hB3);
    wait_done(30);
    chk("stall_n", 32'(rlog.size()), 32'd3);
    for (int j = 0; j < rlog.size(); j++) chk("stall_data", 32'(rlog[j]), 32'(8'hB1 + j));

    // Zero-length burst.
    rd_start = 1'b1; rd_size = 0;
    cycle();
    chk("size0_pop0", 32'(s_pop), 32'd0);
    cycle();
    chk("size0_done", 32'(s_rd_done), 32'd1);
    chk("size0_busy", 32'(s_rd_busy), 32'd0);
    chk("size0_pop1", 32'(s_pop), 32'd0);

    // rd_start while busy is ignored.
    rlog.delete();
    rd_start = 1'b1; rd_size = 2;
    cycle(); cycle();
    rd_start = 1'b1; rd_size = 5;
    cycle();
    load(0, 8'hC1); load(0, 8'hC2);
    wait_done(30);
    chk("ignore_n", 32'(rlog.size()), 32'd2);
    repeat (4) cycle();
    chk("ignore_idle", 32'(s_rd_busy), 32'd0);

    // Reset mid-burst abandons it.
    load(2, 8'hD1);
    cycle();
    rd_start = 1'b1; rd_size = 3;
    repeat (3) cycle();
    reset = 1'b0;
    cycle(); cycle();
    chk("rst_busy", 32'(s_rd_busy), 32'd0);
    reset = 1'b1;
    nd = 0;
    for (int j = 0; j < 5; j++) begin cycle(); nd += int'(s_rd_done); end
    chk("rst_no_done", 32'(nd), 32'd0);
    load(2, 8'hE1); load(2, 8'hE2);
    cycle(); cycle();
    rlog.delete();
    rd_start = 1'b1; rd_size = 2;
    wait_done(20);
    chk("post_rst_n", 32'(rlog.size()), 32'd2);
    for (int j = 0; j < rlog.size(); j++) chk("post_rst_data", 32'(rlog[j]), 32'(8'hE1 + j));

    // Back-to-back bursts: new start in the rd_done cycle.
    load(0, 8'hF1); load(0, 8'hF2); load(0, 8'hF3);
    repeat (3) cycle();
    rlog.delete();
    rd_start = 1'b1; rd_size = 1;
    cycle();
    for (int j = 0; j < 10; j++) begin
      if (e_done) break;
      cycle();
    end
    rd_start = 1'b1; rd_size = 2;
    cycle();
    chk("b2b_done", 32'(s_rd_done), 32'd1);
    wait_done(20);
    chk("b2b_n", 32'(rlog.size()), 32'd3);
    for (int j = 0; j < rlog.size(); j++) chk("b2b_data", 32'(rlog[j]), 32'(8'hF1 + j));

    // Randomized traffic with a shallow FIFO.
    depth = 4;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, NREQ - 1);
      if ($urandom_range(0, 2) == 0 && 8'(rtail[r] - rhead[r]) < 8'd200) load(r, 8'($urandom));
      force_ful = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) begin rd_start = 1'b1; rd_size = $urandom_range(0, 6); end
      if (!valid && !m_phase && $urandom_range(0, 7) == 0) begin valid = 1'b1; r_data = 8'($urandom); end
      reset = ($urandom_range(0, 249) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
